// File: rtl/gpio_cmd_decoder.sv
// gpio_cmd_decoder
// Fabric-side responder for the MicroBlaze 32-bit GPIO command word.
// Turns rising edges of the MCU valid bit into single-cycle kernel/pixel
// write strobes, a start pulse and result-read requests. It also packs FSM
// state, busy, read-valid, error and the last returned result into the
// inbound status word.
module gpio_cmd_decoder #(
    parameter int DATA_W = 24,
    parameter int LEN_W  = 10,
    parameter int ROWS   = 4,
    parameter int KWORDS = 3
) (
    input  logic              CLK100MHZ,
    input  logic              i_rst,
    input  logic [31:0]       i_gpio_data,
    output logic [31:0]       o_gpio_data,
    output logic [DATA_W-1:0] o_kernel_data,
    output logic              o_kernel_we,
    output logic [1:0]        o_kernel_idx,
    output logic [LEN_W-1:0]  o_img_len,
    output logic [DATA_W-1:0] o_img_data,
    output logic              o_img_we,
    output logic [LEN_W+1:0]  o_img_addr,
    output logic              o_start,
    input  logic              i_done,
    output logic              o_rd_req,
    output logic [LEN_W+1:0]  o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_valid
);

    localparam int CNT_W  = LEN_W + 2;
    localparam int KIDX_W = $clog2(KWORDS + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [KIDX_W-1:0] KIDX_ONE = KIDX_W'(1);
    localparam logic [KIDX_W-1:0] KIDX_MAX = KIDX_W'(KWORDS);

    localparam logic [2:0] CMD_KERNEL = 3'b000;
    localparam logic [2:0] CMD_LEN    = 3'b001;
    localparam logic [2:0] CMD_IMAGE  = 3'b010;
    localparam logic [2:0] CMD_READ   = 3'b011;
    localparam logic [2:0] CMD_LAST   = 3'b100;

    // State values are visible to software in status bits 31:29.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PROC   = 3'd2,
        ST_READ   = 3'd3,
        ST_WAITRD = 3'd4
    } state_t;

    // Fields of the outbound MCU word.
    logic [2:0]        cmd_ctrl;
    logic              cmd_valid;
    logic [23:0]       cmd_data;
    logic              soft_rst;
    logic              cmd_event;
    logic              cmd_illegal;
    logic [DATA_W-1:0] payload;
    logic              unused_rsv;

    assign cmd_ctrl    = i_gpio_data[31:29];
    assign cmd_valid   = i_gpio_data[28];
    assign cmd_data    = i_gpio_data[24:1];
    assign soft_rst    = i_gpio_data[0];
    assign payload     = cmd_data[DATA_W-1:0];
    assign cmd_illegal = cmd_ctrl[2] & (cmd_ctrl[1] | cmd_ctrl[0]);
    assign unused_rsv  = ^i_gpio_data[27:25];

    // Registered state
    state_t            state_reg,       state_next;
    logic              valid_q_reg,     valid_q_next;
    logic [KIDX_W-1:0] kidx_reg,        kidx_next;
    logic [CNT_W-1:0]  pidx_reg,        pidx_next;
    logic [CNT_W-1:0]  ridx_reg,        ridx_next;
    logic [LEN_W-1:0]  img_len_reg,     img_len_next;
    logic              err_reg,         err_next;
    logic              rd_valid_reg,    rd_valid_next;
    logic [DATA_W-1:0] rd_data_reg,     rd_data_next;
    logic              start_pend_reg,  start_pend_next;
    logic              start_reg,       start_next;
    logic              kernel_we_reg,   kernel_we_next;
    logic [DATA_W-1:0] kernel_data_reg, kernel_data_next;
    logic [1:0]        kernel_idx_reg,  kernel_idx_next;
    logic              img_we_reg,      img_we_next;
    logic [DATA_W-1:0] img_data_reg,    img_data_next;
    logic [CNT_W-1:0]  img_addr_reg,    img_addr_next;
    logic              rd_req_reg,      rd_req_next;
    logic [CNT_W-1:0]  rd_addr_reg,     rd_addr_next;

    // Pixel count for the current length; wraps in CNT_W bits like the hardware counters.
    logic [CNT_W-1:0] exp_count;
    logic [CNT_W-1:0] last_idx;

    assign exp_count = CNT_W'(ROWS) * ({2'b00, img_len_reg} + CNT_ONE);
    assign last_idx  = exp_count - CNT_ONE;

    assign cmd_event = cmd_valid & ~valid_q_reg;

    // Next-state and strobe decode; soft reset overrides everything last.
    always_comb begin
        state_next       = state_reg;
        valid_q_next     = cmd_valid;
        kidx_next        = kidx_reg;
        pidx_next        = pidx_reg;
        ridx_next        = ridx_reg;
        img_len_next     = img_len_reg;
        err_next         = err_reg;
        rd_valid_next    = rd_valid_reg;
        rd_data_next     = rd_data_reg;
        start_pend_next  = 1'b0;
        start_next       = start_pend_reg;
        kernel_we_next   = 1'b0;
        kernel_data_next = kernel_data_reg;
        kernel_idx_next  = kernel_idx_reg;
        img_we_next      = 1'b0;
        img_data_next    = img_data_reg;
        img_addr_next    = img_addr_reg;
        rd_req_next      = 1'b0;
        rd_addr_next     = rd_addr_reg;

        if (cmd_event && cmd_illegal) begin
            err_next = 1'b1;
        end

        unique case (state_reg)
            ST_IDLE: begin
                // Length follows the data bus level while selected, no valid edge needed.
                if (cmd_ctrl == CMD_LEN) begin
                    img_len_next = cmd_data[LEN_W-1:0];
                end
                if (cmd_event && cmd_ctrl == CMD_KERNEL) begin
                    if (kidx_reg >= KIDX_MAX) begin
                        err_next = 1'b1;
                    end else begin
                        kernel_we_next   = 1'b1;
                        kernel_data_next = payload;
                        kernel_idx_next  = 2'(kidx_reg);
                        kidx_next        = kidx_reg + KIDX_ONE;
                    end
                end
                if (cmd_event && cmd_ctrl == CMD_IMAGE) begin
                    if (pidx_reg >= exp_count) begin
                        err_next = 1'b1;
                    end else begin
                        img_we_next   = 1'b1;
                        img_data_next = payload;
                        img_addr_next = pidx_reg;
                        pidx_next     = pidx_reg + CNT_ONE;
                        state_next    = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (cmd_event && cmd_ctrl == CMD_IMAGE) begin
                    if (pidx_reg >= exp_count) begin
                        err_next = 1'b1;
                    end else begin
                        img_we_next   = 1'b1;
                        img_data_next = payload;
                        img_addr_next = pidx_reg;
                        pidx_next     = pidx_reg + CNT_ONE;
                    end
                end
                if (cmd_event && cmd_ctrl == CMD_LAST) begin
                    if (pidx_reg >= exp_count) begin
                        err_next = 1'b1;
                    end else begin
                        // A short image is flagged but still processed.
                        if (pidx_reg != last_idx) begin
                            err_next = 1'b1;
                        end
                        img_we_next   = 1'b1;
                        img_data_next = payload;
                        img_addr_next = pidx_reg;
                        pidx_next     = pidx_reg + CNT_ONE;
                    end
                    // Start trails the last write by one cycle so memory sees it first.
                    start_pend_next = 1'b1;
                    state_next      = ST_PROC;
                end
            end

            ST_PROC: begin
                if (cmd_event) begin
                    err_next = 1'b1;
                end
                if (i_done) begin
                    ridx_next  = '0;
                    state_next = ST_READ;
                end
            end

            ST_READ: begin
                if (cmd_event && cmd_ctrl == CMD_READ) begin
                    rd_req_next   = 1'b1;
                    rd_addr_next  = ridx_reg;
                    rd_valid_next = 1'b0;
                    state_next    = ST_WAITRD;
                end
            end

            ST_WAITRD: begin
                if (i_rd_valid) begin
                    rd_data_next  = i_rd_data;
                    rd_valid_next = 1'b1;
                    ridx_next     = ridx_reg + CNT_ONE;
                    if (ridx_reg == last_idx) begin
                        kidx_next  = '0;
                        pidx_next  = '0;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (soft_rst) begin
            state_next       = ST_IDLE;
            valid_q_next     = 1'b0;
            kidx_next        = '0;
            pidx_next        = '0;
            ridx_next        = '0;
            img_len_next     = '0;
            err_next         = 1'b0;
            rd_valid_next    = 1'b0;
            rd_data_next     = '0;
            start_pend_next  = 1'b0;
            start_next       = 1'b0;
            kernel_we_next   = 1'b0;
            kernel_data_next = '0;
            kernel_idx_next  = '0;
            img_we_next      = 1'b0;
            img_data_next    = '0;
            img_addr_next    = '0;
            rd_req_next      = 1'b0;
            rd_addr_next     = '0;
        end
    end

    // State register bank with asynchronous hardware reset.
    always_ff @(posedge CLK100MHZ or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= ST_IDLE;
            valid_q_reg     <= 1'b0;
            kidx_reg        <= '0;
            pidx_reg        <= '0;
            ridx_reg        <= '0;
            img_len_reg     <= '0;
            err_reg         <= 1'b0;
            rd_valid_reg    <= 1'b0;
            rd_data_reg     <= '0;
            start_pend_reg  <= 1'b0;
            start_reg       <= 1'b0;
            kernel_we_reg   <= 1'b0;
            kernel_data_reg <= '0;
            kernel_idx_reg  <= '0;
            img_we_reg      <= 1'b0;
            img_data_reg    <= '0;
            img_addr_reg    <= '0;
            rd_req_reg      <= 1'b0;
            rd_addr_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            valid_q_reg     <= valid_q_next;
            kidx_reg        <= kidx_next;
            pidx_reg        <= pidx_next;
            ridx_reg        <= ridx_next;
            img_len_reg     <= img_len_next;
            err_reg         <= err_next;
            rd_valid_reg    <= rd_valid_next;
            rd_data_reg     <= rd_data_next;
            start_pend_reg  <= start_pend_next;
            start_reg       <= start_next;
            kernel_we_reg   <= kernel_we_next;
            kernel_data_reg <= kernel_data_next;
            kernel_idx_reg  <= kernel_idx_next;
            img_we_reg      <= img_we_next;
            img_data_reg    <= img_data_next;
            img_addr_reg    <= img_addr_next;
            rd_req_reg      <= rd_req_next;
            rd_addr_reg     <= rd_addr_next;
        end
    end

    assign o_kernel_we   = kernel_we_reg;
    assign o_kernel_data = kernel_data_reg;
    assign o_kernel_idx  = kernel_idx_reg;
    assign o_img_len     = img_len_reg;
    assign o_img_we      = img_we_reg;
    assign o_img_data    = img_data_reg;
    assign o_img_addr    = img_addr_reg;
    assign o_start       = start_reg;
    assign o_rd_req      = rd_req_reg;
    assign o_rd_addr     = rd_addr_reg;

    // Status word: {state, busy, rd_valid, err, 2'b0, rd_data}.
    assign o_gpio_data = {state_reg, (state_reg == ST_PROC), rd_valid_reg, err_reg,
                          2'b00, 24'(rd_data_reg)};

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Randomized scoreboard bench for gpio_cmd_decoder: stimulus tasks update a
// behavioural model and queue expected strobes; a negedge monitor pops and
// compares whenever the DUT raises a strobe.
module tb_gpio_cmd_decoder;

    localparam int DATA_W = 24;
    localparam int LEN_W  = 10;
    localparam int ROWS   = 4;
    localparam int KWORDS = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       gpio_in = '0;
    logic [31:0]       gpio_out;
    logic [DATA_W-1:0] kernel_data;
    logic              kernel_we;
    logic [1:0]        kernel_idx;
    logic [LEN_W-1:0]  img_len;
    logic [DATA_W-1:0] img_data;
    logic              img_we;
    logic [LEN_W+1:0]  img_addr;
    logic              start;
    logic              done = 1'b0;
    logic              rd_req;
    logic [LEN_W+1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              rd_valid = 1'b0;

    gpio_cmd_decoder #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .ROWS(ROWS), .KWORDS(KWORDS)
    ) dut (
        .CLK100MHZ    (clk),
        .i_rst        (rst),
        .i_gpio_data  (gpio_in),
        .o_gpio_data  (gpio_out),
        .o_kernel_data(kernel_data),
        .o_kernel_we  (kernel_we),
        .o_kernel_idx (kernel_idx),
        .o_img_len    (img_len),
        .o_img_data   (img_data),
        .o_img_we     (img_we),
        .o_img_addr   (img_addr),
        .o_start      (start),
        .i_done       (done),
        .o_rd_req     (rd_req),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .i_rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int a;
        int d;
    } exp_t;

    exp_t kq[$];
    exp_t iq[$];
    exp_t rq[$];
    exp_t sq[$];
    exp_t mon_e;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: protocol-level view of the responder.
    int m_state = 0;
    int m_kidx  = 0;
    int m_pidx  = 0;
    int m_ridx  = 0;
    int m_len   = 0;
    int m_err   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int exp_cnt();
        return (ROWS * (m_len + 1)) % 4096;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_kidx = 0; m_pidx = 0; m_ridx = 0; m_len = 0; m_err = 0;
        kq.delete(); iq.delete(); rq.delete(); sq.delete();
    endfunction

    // Applies one valid-edge command to the model; c is the cycle the strobe should show.
    function automatic void model_event(input int ctrl, input int data, input int c);
        int ec;
        ec = exp_cnt();
        if (ctrl >= 5) begin
            m_err = 1;
            return;
        end
        case (m_state)
            0: begin
                if (ctrl == 0) begin
                    if (m_kidx >= KWORDS) m_err = 1;
                    else begin
                        kq.push_back(exp_t'{cyc: c, a: m_kidx, d: data});
                        m_kidx++;
                    end
                end else if (ctrl == 2) begin
                    if (m_pidx >= ec) m_err = 1;
                    else begin
                        iq.push_back(exp_t'{cyc: c, a: m_pidx, d: data});
                        m_pidx++;
                        m_state = 1;
                    end
                end
            end
            1: begin
                if (ctrl == 2) begin
                    if (m_pidx >= ec) m_err = 1;
                    else begin
                        iq.push_back(exp_t'{cyc: c, a: m_pidx, d: data});
                        m_pidx++;
                    end
                end else if (ctrl == 4) begin
                    if (m_pidx >= ec) m_err = 1;
                    else begin
                        if (m_pidx != ec - 1) m_err = 1;
                        iq.push_back(exp_t'{cyc: c, a: m_pidx, d: data});
                        m_pidx++;
                    end
                    sq.push_back(exp_t'{cyc: c + 1, a: 0, d: 0});
                    m_state = 2;
                end
            end
            2: m_err = 1;
            3: begin
                if (ctrl == 3) begin
                    rq.push_back(exp_t'{cyc: c, a: m_ridx, d: 0});
                    m_state = 4;
                end
            end
            default: ;
        endcase
    endfunction

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (kernel_we) begin
            chk("kernel_we_expected", longint'(kq.size() != 0), 1);
            if (kq.size() != 0) begin
                mon_e = kq.pop_front();
                chk("kernel_cycle", cyc, mon_e.cyc);
                chk("kernel_idx", kernel_idx, mon_e.a);
                chk("kernel_data", kernel_data, mon_e.d);
            end
        end
        if (img_we) begin
            chk("img_we_expected", longint'(iq.size() != 0), 1);
            if (iq.size() != 0) begin
                mon_e = iq.pop_front();
                chk("img_cycle", cyc, mon_e.cyc);
                chk("img_addr", img_addr, mon_e.a);
                chk("img_data", img_data, mon_e.d);
            end
        end
        if (rd_req) begin
            chk("rd_req_expected", longint'(rq.size() != 0), 1);
            chk("rd_valid_cleared", gpio_out[27], 0);
            if (rq.size() != 0) begin
                mon_e = rq.pop_front();
                chk("rd_req_cycle", cyc, mon_e.cyc);
                chk("rd_addr", rd_addr, mon_e.a);
            end
        end
        if (start) begin
            chk("start_expected", longint'(sq.size() != 0), 1);
            if (sq.size() != 0) begin
                mon_e = sq.pop_front();
                chk("start_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Result memory stand-in: answers addr+0x100 two cycles after each request.
    int resp_addr;
    always begin
        @(negedge clk);
        if (rd_req) begin
            resp_addr = int'(rd_addr);
            repeat (2) @(negedge clk);
            rd_data  = 24'(resp_addr + 'h100);
            rd_valid = 1'b1;
            @(negedge clk);
            rd_valid = 1'b0;
        end
    end

    task automatic chk_status(input string name);
        chk({name, "_state"}, gpio_out[31:29], m_state);
        chk({name, "_busy"}, gpio_out[28], longint'(m_state == 2));
        chk({name, "_err"}, gpio_out[26], m_err);
    endtask

    // Raises valid with a new command; returns one cycle later with valid still high.
    task automatic issue(input logic [2:0] ctrl, input logic [23:0] data);
        gpio_in = {ctrl, 1'b1, 3'b000, data, 1'b0};
        model_event(int'(ctrl), int'(data), cyc + 1);
        $display("event ctrl=%0d data=0x%06h cycle=%0d", ctrl, data, cyc + 1);
        @(negedge clk);
    endtask

    // Full command: random extra valid hold (data scrambled) and random low gap.
    task automatic send(input logic [2:0] ctrl, input logic [23:0] data);
        int hold = $urandom_range(0, 4);
        int gap  = $urandom_range(1, 3);
        issue(ctrl, data);
        repeat (hold) begin
            gpio_in[24:1] = 24'($urandom);
            @(negedge clk);
        end
        gpio_in[28] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic set_len(input int len);
        gpio_in = {3'b001, 1'b0, 3'b000, 14'd0, 10'(len), 1'b0};
        repeat (2) @(negedge clk);
        if (m_state == 0) m_len = len;
        chk("img_len", img_len, m_len);
        chk_status("len");
        gpio_in = '0;
        @(negedge clk);
    endtask

    task automatic soft_reset();
        gpio_in = 32'h0000_0001;
        model_reset();
        repeat (2) @(negedge clk);
        chk("soft_rst_status", gpio_out, 0);
        gpio_in = '0;
        @(negedge clk);
    endtask

    task automatic load_frame(input int npix, input bit rand_data);
        for (int i = 0; i < npix; i++) send(3'b010, rand_data ? 24'($urandom) : 24'(i));
        send(3'b100, rand_data ? 24'($urandom) : 24'(npix));
        chk_status("frame");
    endtask

    task automatic pulse_done();
        repeat ($urandom_range(2, 5)) @(negedge clk);
        done = 1'b1;
        if (m_state == 2) begin
            m_state = 3;
            m_ridx  = 0;
        end
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic read_one();
        int waited = 0;
        send(3'b011, 24'($urandom));
        while (!gpio_out[27] && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("rd_wait_in_budget", longint'(waited < 30), 1);
        chk("rd_data", gpio_out[23:0], (m_ridx + 'h100) & 'hFFFFFF);
        m_ridx++;
        if (m_ridx >= exp_cnt()) begin
            m_state = 0; m_kidx = 0; m_pidx = 0;
        end else begin
            m_state = 3;
        end
        chk_status("read");
    endtask

    task automatic read_all();
        int n = exp_cnt();
        for (int i = 0; i < n; i++) read_one();
    endtask

    initial begin
        int l;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_status", gpio_out, 0);
        chk("reset_img_len", img_len, 0);
        chk("reset_strobes", {kernel_we, img_we, start, rd_req}, 0);

        // Kernel words, then one too many.
        send(3'b000, 24'h000);
        send(3'b000, 24'h100);
        send(3'b000, 24'h000);
        chk_status("kernel3");
        send(3'b000, 24'($urandom));
        chk_status("kernel4");
        soft_reset();

        // Full 40-pixel frame and its 40 reads.
        set_len(9);
        load_frame(39, 1'b0);
        pulse_done();
        read_all();

        // Short frame: start still issued, err flagged.
        load_frame(38, 1'b0);
        pulse_done();
        chk_status("short_done");

        // Hardware reset while waiting for a result.
        issue(3'b011, 24'($urandom));
        chk_status("waitrd");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_status", gpio_out, 0);
        chk("async_rst_strobes", {kernel_we, img_we, start, rd_req}, 0);
        chk("async_rst_len", img_len, 0);
        model_reset();
        gpio_in = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Soft reset mid-load while valid is held high.
        set_len(9);
        send(3'b000, 24'($urandom));
        for (int i = 0; i < 3; i++) send(3'b010, 24'($urandom));
        gpio_in = {3'b010, 1'b1, 3'b000, 24'($urandom), 1'b1};
        model_reset();
        repeat (4) begin
            @(negedge clk);
            chk("srst_hold_status", gpio_out, 0);
            chk("srst_hold_len", img_len, 0);
        end
        gpio_in[28] = 1'b0;
        @(negedge clk);
        gpio_in = '0;
        @(negedge clk);

        // Random-length frame from a clean start: counters must restart at 0.
        l = $urandom_range(0, 3);
        set_len(l);
        for (int i = 0; i < KWORDS; i++) send(3'b000, 24'($urandom));
        load_frame(ROWS * (l + 1) - 1, 1'b1);
        pulse_done();
        read_all();
        send(3'($urandom_range(5, 7)), 24'($urandom));
        chk_status("illegal");

        repeat (5) @(negedge clk);
        chk("kernel_queue_drained", kq.size(), 0);
        chk("img_queue_drained", iq.size(), 0);
        chk("rd_queue_drained", rq.size(), 0);
        chk("start_queue_drained", sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
